// File: rtl/prim_cdc_inj_pkg.sv
// Shared types and constants for the delay-injecting CDC synchroniser.
package prim_cdc_inj_pkg;

    localparam int unsigned LfsrWidth = 16;
    localparam logic [LfsrWidth-1:0] LfsrMask = 16'hB400;
    localparam logic [LfsrWidth-1:0] LfsrDefaultSeed = 16'hACE1;

    typedef enum logic [1:0] {
        CdcInjOff    = 2'b00,
        CdcInjRandom = 2'b01,
        CdcInjAlways = 2'b10,
        CdcInjRsvd   = 2'b11
    } cdc_inj_mode_e;

    // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
    function automatic logic [LfsrWidth-1:0] lfsr_step(logic [LfsrWidth-1:0] state);
        return (state >> 1) ^ (state[0] ? LfsrMask : '0);
    endfunction

endpackage

// File: rtl/prim_cdc_inj_lfsr.sv
// 16-bit Galois LFSR with enable and seed load; a zero seed falls back to Seed.
module prim_cdc_inj_lfsr
    import prim_cdc_inj_pkg::*;
#(
    parameter logic [LfsrWidth-1:0] Seed = LfsrDefaultSeed
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en,
    input  logic                 load,
    input  logic [LfsrWidth-1:0] seed,
    output logic [LfsrWidth-1:0] state
);

    logic [LfsrWidth-1:0] state_q;
    logic [LfsrWidth-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (seed == '0) ? Seed : seed;
        end else if (en) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/prim_cdc_sync_delay_inj.sv
// Multi-stage flop synchroniser with optional LFSR-driven one-cycle delay injection.
// Injection logic is built only when PRIM_CDC_DELAY_INJ_EN is defined.
module prim_cdc_sync_delay_inj
    import prim_cdc_inj_pkg::*;
#(
    parameter int unsigned          Width     = 1,
    parameter int unsigned          NumStages = 2,
    parameter logic [LfsrWidth-1:0] LfsrSeed  = LfsrDefaultSeed,
    parameter int unsigned          CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [Width-1:0]     data_i,
    input  logic [1:0]           mode_i,
    input  logic                 seed_load_i,
    input  logic [LfsrWidth-1:0] seed_i,
    output logic [Width-1:0]     data_o,
    output logic                 inj_pulse_o,
    output logic [CntWidth-1:0]  inj_cnt_o
);

    logic [NumStages-1:0][Width-1:0] stage_q;
    logic [Width-1:0]                stage0_d;
    logic [Width-1:0]                sel;

    // A selected bit re-captures its own first-stage value, i.e. skips one update.
    assign stage0_d = (stage_q[0] & sel) | (data_i & ~sel);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= stage0_d;
            for (int s = 1; s < NumStages; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign data_o = stage_q[NumStages-1];

`ifdef PRIM_CDC_DELAY_INJ_EN

    cdc_inj_mode_e        mode;
    logic [LfsrWidth-1:0] lfsr_q;
    logic [Width-1:0]     changed;
    logic [Width-1:0]     held_q;
    logic                 pulse_q;
    logic [CntWidth-1:0]  cnt_q;
    logic                 unused_lfsr;

    assign mode    = cdc_inj_mode_e'(mode_i);
    assign changed = data_i ^ stage_q[0];

    prim_cdc_inj_lfsr #(
        .Seed(LfsrSeed)
    ) u_lfsr (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en    (mode == CdcInjRandom),
        .load  (seed_load_i),
        .seed  (seed_i),
        .state (lfsr_q)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < Width; i++) begin
            case (mode)
                CdcInjAlways: sel[i] = changed[i] & ~held_q[i];
                CdcInjRandom: sel[i] = changed[i] & ~held_q[i] & lfsr_q[i % LfsrWidth];
                default:      sel[i] = 1'b0;
            endcase
        end
    end

    // held_q bounds the extra latency to a single cycle per bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            held_q  <= '0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            held_q  <= sel;
            pulse_q <= |sel;
            if (|sel && !(&cnt_q)) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end
        end
    end

    assign inj_pulse_o = pulse_q;
    assign inj_cnt_o   = cnt_q;
    assign unused_lfsr = ^lfsr_q;

`else

    logic unused_cfg;

    assign sel         = '0;
    assign inj_pulse_o = 1'b0;
    assign inj_cnt_o   = '0;
    assign unused_cfg  = ^{mode_i, seed_load_i, seed_i, LfsrSeed};

`endif

endmodule
